// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default width for the restoring divider.
package div_pkg;
    localparam int WIDTH_DEF = 4;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/div_restoring_seq_if.sv
// div_restoring_seq_if: start/done handshake plus operand and result bus of the divider.
interface div_restoring_seq_if import div_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_sub_step.sv
// div_sub_step: one restoring step, WIDTH+1-bit trial subtraction in add/sub form.
module div_sub_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_shift,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   diff,
    output logic             borrow
);
    assign diff   = rem_shift + ~{1'b0, divisor} + (WIDTH+1)'(1);
    // The partial remainder stays below 2*divisor, so the MSB is the sign of the difference.
    assign borrow = diff[WIDTH];
endmodule

// File: rtl/div_restoring_seq.sv
// div_restoring_seq: sequential unsigned restoring divider, one quotient bit per clock.
module div_restoring_seq import div_pkg::*; #(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int CNT_W = $clog2(WIDTH+1)
) (
    input logic                clk,
    input logic                reset_n,
    div_restoring_seq_if.slave bus
);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d, d_q, d_d, quot_q, quot_d, rem_q, rem_d, q_next;
    logic [WIDTH:0]     r_q, r_d, rem_shift, diff, r_next;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dbz_q, dbz_d, borrow, accept, last;

    assign accept    = state_q == ST_IDLE && bus.start;
    assign last      = state_q == ST_CALC && cnt_q == CNT_W'(1);
    assign rem_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign q_next    = {q_q[WIDTH-2:0], ~borrow};
    assign r_next    = borrow ? rem_shift : diff;

    div_sub_step #(.WIDTH(WIDTH)) u_step (
        .rem_shift (rem_shift),
        .divisor   (d_q),
        .diff      (diff),
        .borrow    (borrow)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == ST_IDLE) ? (bus.start ? ST_CALC : ST_IDLE) :
                  (state_q == ST_CALC) ? (last ? ST_DONE : ST_CALC) : ST_IDLE;
    end

    always_comb begin
        bus.busy = state_q != ST_IDLE;
        bus.done = state_q == ST_DONE;
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

    // A zero divisor spends a single CALC cycle that loads the saturated result instead of stepping.
    always_comb begin
        q_d    = q_q;
        d_d    = d_q;
        r_d    = r_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        if (accept) begin
            q_d   = bus.dividend;
            d_d   = bus.divisor;
            r_d   = '0;
            dbz_d = bus.divisor == '0;
            cnt_d = (bus.divisor == '0) ? CNT_W'(1) : CNT_W'(WIDTH);
        end else if (state_q == ST_CALC) begin
            q_d   = q_next;
            r_d   = r_next;
            cnt_d = cnt_q - CNT_W'(1);
            if (last) begin
                quot_d = dbz_q ? '1 : q_next;
                rem_d  = dbz_q ? q_q : r_next[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= '0;
            d_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            d_q    <= d_d;
            r_q    <= r_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end
endmodule

// File: tb/tb_div_restoring_seq.sv
// tb_div_restoring_seq: random and directed stimulus checked every cycle against an arithmetic model.
module tb_div_restoring_seq;
    localparam int W    = 4;
    localparam int ONES = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    div_restoring_seq_if #(.WIDTH(W)) bus ();
    div_restoring_seq #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    // Model: busy cycles left, results published when the done cycle begins.
    int m_left, m_q, m_r, m_z, p_q, p_r;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left <= 0;
            m_q    <= 0;
            m_r    <= 0;
            m_z    <= 0;
            p_q    <= 0;
            p_r    <= 0;
        end else if (m_left == 0) begin
            if (bus.start) begin
                m_left <= (bus.divisor == 0) ? 2 : W + 1;
                m_z    <= (bus.divisor == 0) ? 1 : 0;
                p_q    <= (bus.divisor == 0) ? ONES : int'(bus.dividend) / int'(bus.divisor);
                p_r    <= (bus.divisor == 0) ? int'(bus.dividend) : int'(bus.dividend) % int'(bus.divisor);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_q <= p_q;
                m_r <= p_r;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_busy", 32'(bus.busy), 32'(m_left != 0));
        chk("model_done", 32'(bus.done), 32'(m_left == 1));
        chk("model_quotient", 32'(bus.quotient), 32'(m_q));
        chk("model_remainder", 32'(bus.remainder), 32'(m_r));
        chk("model_dbz", 32'(bus.div_by_zero), 32'(m_z));
    end

    task automatic launch(input int a, input int b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = W'(a);
        bus.divisor  = W'(b);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_op(input int a, input int b, input int eq, input int er, input int ez, input int el);
        int n;
        launch(a, b);
        chk("busy_after_start", 32'(bus.busy), 1);
        wait_done(1, n);
        chk("latency", 32'(n), 32'(el));
        chk("quotient", 32'(bus.quotient), 32'(eq));
        chk("remainder", 32'(bus.remainder), 32'(er));
        chk("dbz", 32'(bus.div_by_zero), 32'(ez));
        @(negedge clk);
        chk("idle_after_done", 32'({bus.busy, bus.done}), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, dones, prev;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero}), 0);
        reset_n = 1'b1;
        do_op(13, 3, 4, 1, 0, 5);
        do_op(15, 15, 1, 0, 0, 5);
        do_op(15, 1, 15, 0, 0, 5);
        do_op(0, 7, 0, 0, 0, 5);
        do_op(4, 9, 0, 4, 0, 5);
        do_op(7, 0, 15, 7, 1, 2);
        do_op(8, 2, 4, 0, 0, 5);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                do_op(a, b, b != 0 ? a / b : ONES, b != 0 ? a % b : a, b == 0 ? 1 : 0, b != 0 ? W + 1 : 2);
        launch(13, 3);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 4'd9;
        bus.divisor  = 4'd3;
        @(negedge clk);
        bus.start    = 1'b0;
        wait_done(3, n);
        chk("ignored_latency", 32'(n), 5);
        chk("ignored_quotient", 32'(bus.quotient), 4);
        chk("ignored_remainder", 32'(bus.remainder), 1);
        repeat (3) @(negedge clk);
        chk("hold_quotient", 32'(bus.quotient), 4);
        chk("hold_remainder", 32'(bus.remainder), 1);
        chk("hold_idle", 32'(bus.busy), 0);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 4'd14;
        bus.divisor  = 4'd4;
        dones = 0;
        prev  = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                chk("held_quotient", 32'(bus.quotient), 3);
                chk("held_remainder", 32'(bus.remainder), 2);
                if (prev >= 0) chk("held_interval", 32'(i - prev), 6);
                prev = i;
            end
        end
        chk("held_done_count", 32'(dones), 6);
        bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("held_drain", 32'(bus.busy), 0);
        launch(13, 3);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk("async_reset", 32'({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero}), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        chk("no_resume_after_reset", 32'(dones), 0);
        do_op(9, 4, 2, 1, 0, 5);
        repeat (600) begin
            @(negedge clk);
            bus.start    = ($urandom_range(0, 2) == 0);
            bus.dividend = W'($urandom);
            bus.divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        end
        bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("random_drain", 32'(bus.busy), 0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
